mem_port_arbiter: RTL and testbench

//  Shares one single-port, variable-latency memory between instruction fetch (IF) and load/store (MEM).

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 24 ++
 rtl/mem_port_arbiter_lane_steer.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: access size codes,
// FSM state encoding and the alignment rule used at grant time.
package mem_port_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_D_ACC,
    ST_I_ACC,
    ST_D_FAULT
  } state_t;

  // The illegal code 2'b10 falls into the word rule.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = ofs[0];
      default: misaligned = |ofs;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Unified single-port memory bus: the arbiter is the master, the memory the slave.
interface mem_port_arbiter_if #(
  parameter int AW = 32
) ();

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_port_arbiter_lane_steer.sv
// Byte-lane logic: store byte enables and lane replication, load lane extract
// and sign/zero extension. Purely combinational.
module mem_port_arbiter_lane_steer
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  ofs_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] lane;
  logic        sext_b;
  logic        sext_h;

  assign lane   = rdata_i >> {ofs_i, 3'b000};
  assign sext_b = ~unsigned_i & lane[7];
  assign sext_h = ~unsigned_i & lane[15];

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << ofs_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sext_b}}, lane[7:0]};
      end
      SZ_HALF: begin
        be_o    = ofs_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sext_h}}, lane[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and
// load/store, with data priority, misalign faulting and an access timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [AW-1:0]       if_addr,
  output logic [31:0]         if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [1:0]          d_size,
  input  logic                d_unsigned,
  input  logic [AW-1:0]       d_addr,
  input  logic [31:0]         d_wdata,
  output logic [31:0]         d_rdata,
  output logic                d_done,
  output logic                d_misalign,
  output logic                bus_err,
  output logic                stall,
  mem_port_arbiter_if.master  mem
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q;
  logic          mem_req_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_wdata_q;
  logic [31:0]   d_rdata_q, if_rdata_q;
  logic          d_done_q, if_valid_q, d_misalign_q, bus_err_q;
  logic [7:0]    cnt_q;
  logic [1:0]    size_q, ofs_q;
  logic          uns_q;

  logic          idle, expire;
  logic [1:0]    ls_size, ls_ofs;
  logic          ls_uns;
  logic [3:0]    ls_be;
  logic [31:0]   ls_wdata, ls_rdata;
  logic          unused_if_ofs;

  assign unused_if_ofs = ^if_addr[1:0];

  // At grant time the live request drives the lane logic; during the access
  // the captured attributes are used to extract the load result.
  assign idle    = (state_q == ST_IDLE);
  assign ls_size = idle ? d_size     : size_q;
  assign ls_ofs  = idle ? d_addr[1:0] : ofs_q;
  assign ls_uns  = idle ? d_unsigned : uns_q;

  mem_port_arbiter_lane_steer u_lane (
    .size_i     (ls_size),
    .unsigned_i (ls_uns),
    .ofs_i      (ls_ofs),
    .wdata_i    (d_wdata),
    .rdata_i    (mem.mem_rdata),
    .be_o       (ls_be),
    .wdata_o    (ls_wdata),
    .rdata_o    (ls_rdata)
  );

  // A ready on the last allowed cycle completes normally.
  assign expire = ~mem.mem_ready && (cnt_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      d_rdata_q    <= '0;
      if_rdata_q   <= '0;
      d_done_q     <= 1'b0;
      if_valid_q   <= 1'b0;
      d_misalign_q <= 1'b0;
      bus_err_q    <= 1'b0;
      cnt_q        <= '0;
      size_q       <= '0;
      ofs_q        <= '0;
      uns_q        <= 1'b0;
    end else begin
      d_done_q     <= 1'b0;
      if_valid_q   <= 1'b0;
      d_misalign_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The cycle carrying a done pulse never grants, so a requester still
          // holding req for the finished access is not served twice.
          if (!(d_done_q || if_valid_q)) begin
            if (d_req && misaligned(d_size, d_addr[1:0])) begin
              state_q      <= ST_D_FAULT;
              d_done_q     <= 1'b1;
              d_misalign_q <= 1'b1;
              d_rdata_q    <= '0;
            end else if (d_req) begin
              state_q     <= ST_D_ACC;
              mem_req_q   <= 1'b1;
              mem_we_q    <= d_we;
              mem_addr_q  <= {d_addr[AW-1:2], 2'b00};
              mem_be_q    <= ls_be;
              mem_wdata_q <= ls_wdata;
              size_q      <= d_size;
              ofs_q       <= d_addr[1:0];
              uns_q       <= d_unsigned;
              cnt_q       <= '0;
            end else if (if_req) begin
              state_q    <= ST_I_ACC;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {if_addr[AW-1:2], 2'b00};
              mem_be_q   <= 4'b1111;
              cnt_q      <= '0;
            end
          end
        end
        ST_D_ACC, ST_I_ACC: begin
          if (mem.mem_ready || expire) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            bus_err_q <= expire;
            if (state_q == ST_D_ACC) begin
              d_done_q  <= 1'b1;
              d_rdata_q <= expire ? '0 : ls_rdata;
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= expire ? '0 : mem.mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_D_FAULT: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;

  assign if_rdata   = if_rdata_q;
  assign if_valid   = if_valid_q;
  assign d_rdata    = d_rdata_q;
  assign d_done     = d_done_q;
  assign d_misalign = d_misalign_q;
  assign bus_err    = bus_err_q;
  assign stall      = (d_req & ~d_done_q) | (if_req & ~if_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory accesses and completions
// are queued as requests are issued and matched as the DUT produces them.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW      = 32;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, d_unsigned;
  logic [1:0]  d_size;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata;
  logic        if_valid, d_done, d_misalign, bus_err, stall;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW)) mem_if ();

  mem_port_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_size     (d_size),
    .d_unsigned (d_unsigned),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_done     (d_done),
    .d_misalign (d_misalign),
    .bus_err    (bus_err),
    .stall      (stall),
    .mem        (mem_if)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } mexp_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rd;
    logic        mis;
    logic        berr;
    logic        chk_rd;
  } oexp_t;

  mexp_t mq[$];
  oexp_t oq[$];
  mexp_t me;
  oexp_t oe;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Memory model: ready on the (mem_lat+1)-th mem_req cycle unless hung.
  int          mem_lat  = 0;
  logic        mem_hang = 1'b0;
  logic [31:0] mem_word = '0;
  int          mcnt     = 0;
  int          last_len = 0;

  initial begin
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_if.mem_req === 1'b1) begin
        mcnt++;
        mem_if.mem_ready = !mem_hang && (mcnt == mem_lat + 1);
        mem_if.mem_rdata = mem_word;
      end else begin
        if (mcnt != 0) last_len = mcnt;
        mcnt = 0;
        mem_if.mem_ready = 1'b0;
      end
    end
  end

  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (mem_if.mem_req === 1'b1 && !req_prev) begin
      if (mq.size() == 0) chk("mem_unexpected", 1, 0);
      else begin
        me = mq.pop_front();
        chk("mem_addr", mem_if.mem_addr, me.addr);
        chk("mem_be", mem_if.mem_be, me.be);
        chk("mem_we", mem_if.mem_we, me.we);
        if (me.we) chk("mem_wdata", mem_if.mem_wdata, me.wd);
      end
    end
    req_prev = (mem_if.mem_req === 1'b1);
  end

  always @(negedge clk) begin
    if (d_done === 1'b1 || if_valid === 1'b1) begin
      if (oq.size() == 0) chk("out_unexpected", 1, 0);
      else begin
        oe = oq.pop_front();
        chk("done_kind", d_done, oe.is_d);
        chk("valid_kind", if_valid, !oe.is_d);
        if (oe.chk_rd) chk("rdata", oe.is_d ? d_rdata : if_rdata, oe.rd);
        chk("misalign", d_misalign, oe.mis);
        chk("bus_err", bus_err, oe.berr);
      end
    end else if (bus_err === 1'b1) begin
      chk("bus_err_stray", bus_err, 0);
    end
  end

  // lat < 0 means the memory never answers.
  task automatic data_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                         input int lat, input logic drop, input logic [3:0] be_e,
                         input logic [31:0] wd_e, input logic [31:0] rd_e, input logic mis_e);
    int k;
    mem_word = word;
    mem_lat  = (lat < 0) ? 0 : lat;
    mem_hang = (lat < 0);
    if (!mis_e) mq.push_back('{a & 32'hFFFF_FFFC, be_e, we, wd_e});
    oq.push_back('{1'b1, rd_e, mis_e, (lat < 0), !we});
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk("stall_busy", stall, !mis_e);
        if (drop) d_req = 1'b0;
      end
    end while (d_done !== 1'b1 && k < 100);
    chk("d_latency", k, mis_e ? 1 : ((lat < 0) ? TIMEOUT + 1 : lat + 2));
    chk("stall_done", stall, 0);
    d_req = 1'b0;
    mem_hang = 1'b0;
  endtask

  task automatic fetch_op(input logic [31:0] a, input logic [31:0] word, input int lat);
    int k;
    mem_word = word;
    mem_lat  = lat;
    mq.push_back('{a, 4'hF, 1'b0, 32'h0});
    oq.push_back('{1'b0, word, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    if_req = 1'b1; if_addr = a;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) chk("if_stall_busy", stall, 1);
    end while (if_valid !== 1'b1 && k < 100);
    chk("if_latency", k, lat + 2);
    chk("if_stall_done", stall, 0);
    if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, kd;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_unsigned = 1'b0;
    d_size = SZ_WORD; if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {mem_if.mem_req, mem_if.mem_we, d_done, if_valid, bus_err, d_misalign,
                     stall, mem_if.mem_be}, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_addr", mem_if.mem_addr, 0);
    rst = 1'b0;

    fetch_op(32'h40, 32'h8C22_0004, 2);

    // Simultaneous requests: data first, fetch after the done cycle plus one idle.
    mem_word = 32'h1122_3344; mem_lat = 0;
    mq.push_back('{32'h100, 4'hF, 1'b0, 32'h0});
    mq.push_back('{32'h80, 4'hF, 1'b0, 32'h0});
    oq.push_back('{1'b1, 32'h1122_3344, 1'b0, 1'b0, 1'b1});
    oq.push_back('{1'b0, 32'h1122_3344, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_size = SZ_WORD; d_unsigned = 1'b0; d_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h80;
    k = 0; kd = 0;
    do begin
      @(negedge clk);
      k++;
      if (d_done === 1'b1) begin kd = k; d_req = 1'b0; end
      if (k == 3) chk("sim_idle_gap", mem_if.mem_req, 0);
    end while (if_valid !== 1'b1 && k < 100);
    chk("sim_d_lat", kd, 2);
    chk("sim_if_lat", k, 5);
    if_req = 1'b0;

    //      we    size     uns   addr        wdata         mem word      lat drop be       wdata_exp     rdata_exp     mis
    data_op(1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0,         32'h80FF_FF12, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0);
    data_op(1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0,         32'h80FF_FF12, 1, 1'b0, 4'b1000, 32'h0,        32'h0000_0080, 1'b0);
    data_op(1'b1, SZ_HALF, 1'b0, 32'h202, 32'h1234_ABCD, 32'h0,         1, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0);
    data_op(1'b0, SZ_WORD, 1'b0, 32'h101, 32'h0,         32'h0,         0, 1'b0, 4'b0000, 32'h0,        32'h0,         1'b1);
    data_op(1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0,         32'h8001_7FFF, 3, 1'b1, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0);
    data_op(1'b0, SZ_HALF, 1'b1, 32'h102, 32'h0,         32'h8001_7FFF, 0, 1'b0, 4'b1100, 32'h0,        32'h0000_8001, 1'b0);
    data_op(1'b0, SZ_HALF, 1'b0, 32'h100, 32'h0,         32'h8001_7FFF, 0, 1'b0, 4'b0011, 32'h0,        32'h0000_7FFF, 1'b0);
    data_op(1'b1, SZ_BYTE, 1'b0, 32'h101, 32'hAABB_CC5A, 32'h0,         2, 1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0,        1'b0);
    data_op(1'b1, SZ_WORD, 1'b0, 32'h204, 32'hDEAD_BEEF, 32'h0,         0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0);
    data_op(1'b0, SZ_HALF, 1'b0, 32'h103, 32'h0,         32'h0,         0, 1'b0, 4'b0000, 32'h0,        32'h0,         1'b1);
    data_op(1'b0, SZ_BYTE, 1'b0, 32'h100, 32'h0,         32'h1234_567F, 0, 1'b0, 4'b0001, 32'h0,        32'h0000_007F, 1'b0);
    data_op(1'b0, 2'b10,   1'b0, 32'h208, 32'h0,         32'hCAFE_F00D, 0, 1'b0, 4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0);
    data_op(1'b1, SZ_HALF, 1'b0, 32'h201, 32'h5555_6666, 32'h0,         0, 1'b0, 4'b0000, 32'h0,        32'h0,         1'b1);
    data_op(1'b0, SZ_BYTE, 1'b0, 32'h102, 32'h0,         32'h00AB_0000, 0, 1'b0, 4'b0100, 32'h0,        32'hFFFF_FFAB, 1'b0);
    data_op(1'b0, SZ_WORD, 1'b0, 32'h300, 32'h0,         32'h1357_2468, 15, 1'b0, 4'b1111, 32'h0,       32'h1357_2468, 1'b0);
    @(negedge clk);
    chk("ready_last_len", last_len, TIMEOUT);
    data_op(1'b0, SZ_WORD, 1'b0, 32'h304, 32'h0,         32'hFFFF_FFFF, -1, 1'b0, 4'b1111, 32'h0,       32'h0,         1'b0);
    @(negedge clk);
    chk("timeout_len", last_len, TIMEOUT);

    // Reset in the middle of an access: bus drops, no completion is reported.
    mem_hang = 1'b1;
    mq.push_back('{32'h400, 4'hF, 1'b0, 32'h0});
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_size = SZ_WORD; d_addr = 32'h400;
    repeat (4) @(negedge clk);
    chk("pre_rst_req", mem_if.mem_req, 1);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_req", mem_if.mem_req, 0);
    chk("rst_mid_done", d_done, 0);
    rst = 1'b0; mem_hang = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_mid_idle", mem_if.mem_req, 0);

    fetch_op(32'h44, 32'h0011_2233, 0);

    repeat (3) @(negedge clk);
    chk("mq_left", mq.size(), 0);
    chk("oq_left", oq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
